// File: rtl/div_module.sv
// div_module: sequential radix-2 restoring unsigned divider, one quotient bit per clock.
module div_module #(
    parameter int N = 64,
    parameter int M = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         done,
    output logic [7:0]   cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] LAST = 8'(N - 1);
    state_t       state_q, state_d;
    logic [N-1:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d, quo_q, quo_d;
    logic [M-1:0] res_q, res_d;
    logic         done_q, done_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [N:0]   r_shift;
    logic         ge;
    always_comb begin
        r_shift = {rem_q, dvd_q[N-1]};
        ge      = r_shift >= {1'b0, dsr_q};
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            // dividend register shifts out MSB-first and fills with quotient bits
            dvd_d = {dvd_q[N-2:0], ge};
            rem_d = ge ? r_shift[N-1:0] - dsr_q : r_shift[N-1:0];
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == LAST) begin
                quo_d   = dvd_d;
                res_d   = rem_d[M-1:0];
                done_d  = 1'b1;
                state_d = DONE;
            end
        end else if (start) begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end
    assign quotient  = quo_q;
    assign remainder = res_q;
    assign done      = done_q;
    assign cnt       = cnt_q;
endmodule

// File: tb/tb_div_module.sv
// tb_div_module: randomized and directed scoreboard bench for div_module (N=M=64).
module tb_div_module;
    logic        clk = 0, rst = 1, start = 0;
    logic [63:0] dividend = '0, divisor = '0, quotient, remainder;
    logic        done;
    logic [7:0]  cnt;
    int          total = 0, bad = 0, cyc = 0;
    logic        done_prev = 0;
    typedef struct {logic [63:0] q; logic [63:0] r; int c;} exp_t;
    exp_t exp_q[$];

    div_module #(.N(64), .M(64)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .done(done), .cnt(cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int c);
        exp_t e;
        e.q = (b == 0) ? '1 : a / b;
        e.r = (b == 0) ? a : a % b;
        e.c = c;
        return e;
    endfunction

    // completion monitor: every rising done pops one expected result
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done act=1 req=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("cnt_final", 64'(cnt), 64'd64);
                chk("latency", 64'(cyc - e.c), 64'd65);
            end
        end
        done_prev = done;
    end

    task automatic go(input logic [63:0] a, input logic [63:0] b, input bit push);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1;
        if (push) exp_q.push_back(model(a, b, cyc));
        @(negedge clk);
        start    = 0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
        end
        total++;
        bad++;
        $display("FAIL done_timeout act=0 req=1");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_cnt", 64'(cnt), 0);
        rst = 0;

        go(64'hFFFF_FFFF_FFFF_FFFF, 64'hF, 1);
        wait_done();
        chk("q_fffff_div_f", quotient, 64'h1111_1111_1111_1111);

        go(64'h64, 64'h7, 1);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            chk("cnt_step", 64'(cnt), 64'(i));
            chk("done_in_run", 64'(done), (i == 64) ? 64'd1 : 64'd0);
        end
        chk("q_100_div_7", quotient, 64'hE);
        chk("r_100_div_7", remainder, 64'h2);

        go(64'h1234_5678_1234_5678, 64'h1, 1);
        wait_done();
        go(64'h5, 64'h9, 1);
        wait_done();
        go(64'hABCD, 64'h0, 1);
        wait_done();
        chk("q_div0", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("r_div0", remainder, 64'hABCD);

        // reset aborts a division in flight
        go(64'hDEAD_BEEF_0000_1234, 64'h77, 1);
        for (int i = 0; i < 100 && cnt != 8'd20; i++) @(negedge clk);
        chk("abort_at_cnt20", 64'(cnt), 64'd20);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_cnt", 64'(cnt), 0);
        exp_q.delete();
        repeat (70) @(negedge clk);
        chk("abort_no_done", 64'(done), 0);
        go(64'd1000003, 64'd97, 1);
        wait_done();

        // start during RUN is ignored
        go(64'd123456789, 64'd1000, 1);
        repeat (10) @(negedge clk);
        go(64'd999, 64'd3, 0);
        wait_done();

        // start in DONE drops done at the accepting edge
        go(64'hFEDC_BA98_7654_3210, 64'h1_0000, 1);
        chk("done_drop", 64'(done), 0);
        wait_done();

        for (int k = 0; k < 20; k++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (k == 3) b = 0;
            if (k == 4) b = a + 1;
            go(a, b, 1);
            wait_done();
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
